// File: rtl/mips32_mem_arbiter_if.sv
// Requester, memory and status bundle around the unified-memory arbiter.
// master: core/loader/memory side; slave: the arbiter.
interface mips32_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          halted;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          if_stall;
  logic          dm_stall;
  logic [31:0]   cnt_if;
  logic [31:0]   cnt_dm;

  modport master (
    output halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, if_stall, dm_stall, cnt_if, cnt_dm
  );

  modport slave (
    input  halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           ld_req, ld_we, ld_addr, ld_wdata, mem_rdata,
    output if_gnt, if_rvalid, dm_gnt, dm_rvalid, ld_gnt, ld_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata, if_stall, dm_stall, cnt_if, cnt_dm
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Fixed-priority (ld > starved if > dm > if) arbiter for the single-port unified memory; loader gated by MIPS32_MEMARB_LOADER_EN.
// Grant is combinational, read data returns 1 cycle later; losers see gnt=0 and must hold their request.
module mips32_mem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk1,
  input logic                 reset,
  mips32_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {SEL_NONE, SEL_IF, SEL_DM, SEL_LD} sel_e;

  sel_e          sel;
  logic          fetch;
  logic          ld_act;
  logic [SW-1:0] starve_cnt;
  logic          pend_if;
  logic          pend_dm;
  logic          pend_ld;
  logic          we_sel;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  assign fetch = bus.if_req && !bus.halted;

`ifdef MIPS32_MEMARB_LOADER_EN
  assign ld_act        = bus.ld_req;
  assign bus.ld_gnt    = (sel == SEL_LD);
  assign bus.ld_rvalid = pend_ld;
`else
  logic unused_ld;
  assign unused_ld     = bus.ld_req;
  assign ld_act        = 1'b0;
  assign bus.ld_gnt    = 1'b0;
  assign bus.ld_rvalid = 1'b0;
`endif

  // Grants are masked during reset so the memory sees no command while it is held.
  always_comb begin
    sel = SEL_NONE;
    if (!reset) begin
      if (ld_act)                              sel = SEL_LD;
      else if (fetch && starve_cnt >= LIMIT)   sel = SEL_IF;
      else if (bus.dm_req)                     sel = SEL_DM;
      else if (fetch)                          sel = SEL_IF;
    end
  end

  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    case (sel)
      SEL_IF: addr_sel = bus.if_addr;
      SEL_DM: begin
        we_sel    = bus.dm_we;
        addr_sel  = bus.dm_addr;
        wdata_sel = bus.dm_wdata;
      end
      SEL_LD: begin
        we_sel    = bus.ld_we;
        addr_sel  = bus.ld_addr;
        wdata_sel = bus.ld_wdata;
      end
      default: ;
    endcase
  end

  assign bus.mem_en    = (sel != SEL_NONE);
  assign bus.mem_we    = we_sel;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.if_gnt    = (sel == SEL_IF);
  assign bus.dm_gnt    = (sel == SEL_DM);
  assign bus.if_stall  = bus.if_req && (sel != SEL_IF);
  assign bus.dm_stall  = bus.dm_req && (sel != SEL_DM);
  assign bus.if_rvalid = pend_if;
  assign bus.dm_rvalid = pend_dm;
  // Memory output is already registered; forward it only while a read is returning.
  assign bus.rdata     = (pend_if || pend_dm || pend_ld) ? bus.mem_rdata : '0;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      pend_if    <= 1'b0;
      pend_dm    <= 1'b0;
      pend_ld    <= 1'b0;
      starve_cnt <= '0;
      bus.cnt_if <= '0;
      bus.cnt_dm <= '0;
    end else begin
      pend_if <= (sel == SEL_IF);
      pend_dm <= (sel == SEL_DM) && !bus.dm_we;
      pend_ld <= (sel == SEL_LD) && !bus.ld_we;
      if (fetch && sel != SEL_IF)
        starve_cnt <= (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 1'b1;
      else
        starve_cnt <= '0;
      if (sel == SEL_IF) bus.cnt_if <= bus.cnt_if + 32'd1;
      if (sel == SEL_DM) bus.cnt_dm <= bus.cnt_dm + 32'd1;
    end
  end
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Random and directed stimulus for mips32_mem_arbiter, checked every cycle against a reference
// model holding its own copy of memory contents and the priority rules.
module tb_mips32_mem_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
`ifdef MIPS32_MEMARB_LOADER_EN
  localparam bit LD_EN = 1'b1;
`else
  localparam bit LD_EN = 1'b0;
`endif

  logic clk1 = 1'b0;
  logic reset;
  always #5 clk1 = ~clk1;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory seen by the DUT
  logic [DW-1:0] mem     [0:1023];
  logic [DW-1:0] ref_mem [0:1023];
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  // Reference model: 0 none, 1 fetch, 2 data, 3 loader
  int          m_starve;
  int          m_pend;
  logic [31:0] m_pdata;
  logic [31:0] m_cnt_if;
  logic [31:0] m_cnt_dm;
  bit          g_if, g_dm, g_ld;

  always @(negedge clk1) begin : compare
    bit fetch;
    int win;
    #1;
    if (reset) begin
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_dm_gnt", bus.dm_gnt, 0);
      chk("rst_ld_gnt", bus.ld_gnt, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_dm_rvalid", bus.dm_rvalid, 0);
      chk("rst_ld_rvalid", bus.ld_rvalid, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_cnt_if", bus.cnt_if, 0);
      chk("rst_cnt_dm", bus.cnt_dm, 0);
      m_starve = 0; m_pend = 0; m_pdata = '0; m_cnt_if = '0; m_cnt_dm = '0;
      g_if = 0; g_dm = 0; g_ld = 0;
    end else begin
      fetch = bus.if_req && !bus.halted;
      if (LD_EN && bus.ld_req)              win = 3;
      else if (fetch && m_starve >= LIMIT)  win = 1;
      else if (bus.dm_req)                  win = 2;
      else if (fetch)                       win = 1;
      else                                  win = 0;

      chk("if_gnt", bus.if_gnt, win == 1);
      chk("dm_gnt", bus.dm_gnt, win == 2);
      chk("ld_gnt", bus.ld_gnt, win == 3);
      chk("mem_en", bus.mem_en, win != 0);
      chk("mem_we", bus.mem_we, (win == 2) ? bus.dm_we : (win == 3) ? bus.ld_we : 1'b0);
      chk("if_stall", bus.if_stall, bus.if_req && win != 1);
      chk("dm_stall", bus.dm_stall, bus.dm_req && win != 2);
      chk("if_rvalid", bus.if_rvalid, m_pend == 1);
      chk("dm_rvalid", bus.dm_rvalid, m_pend == 2);
      chk("ld_rvalid", bus.ld_rvalid, m_pend == 3);
      if (m_pend != 0) chk("rdata", bus.rdata, m_pdata);
      chk("cnt_if", bus.cnt_if, m_cnt_if);
      chk("cnt_dm", bus.cnt_dm, m_cnt_dm);

      m_pend = 0;
      case (win)
        1: begin
          chk("mem_addr_if", bus.mem_addr, bus.if_addr);
          m_pend = 1; m_pdata = ref_mem[bus.if_addr]; m_cnt_if++;
        end
        2: begin
          chk("mem_addr_dm", bus.mem_addr, bus.dm_addr);
          if (bus.dm_we) begin
            chk("mem_wdata_dm", bus.mem_wdata, bus.dm_wdata);
            ref_mem[bus.dm_addr] = bus.dm_wdata;
          end else begin
            m_pend = 2; m_pdata = ref_mem[bus.dm_addr];
          end
          m_cnt_dm++;
        end
        3: begin
          chk("mem_addr_ld", bus.mem_addr, bus.ld_addr);
          if (bus.ld_we) begin
            chk("mem_wdata_ld", bus.mem_wdata, bus.ld_wdata);
            ref_mem[bus.ld_addr] = bus.ld_wdata;
          end else begin
            m_pend = 3; m_pdata = ref_mem[bus.ld_addr];
          end
        end
        default: ;
      endcase
      if (fetch && win != 1) m_starve = (m_starve >= LIMIT) ? LIMIT : m_starve + 1;
      else                   m_starve = 0;
      g_if = bus.if_gnt; g_dm = bus.dm_gnt; g_ld = bus.ld_gnt;
    end
  end

  task automatic idle_inputs();
    bus.if_req = 0; bus.dm_req = 0; bus.ld_req = 0; bus.halted = 0;
  endtask

  initial begin : stim
    logic [5:0] pi6, pd6;
    logic [4:0] pi5;
    int gsum;
    reset = 1'b1;
    bus.halted = 0;
    bus.if_req = 1; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] = v; ref_mem[i] = v;
    end
    mem[0] = 32'hFC000000; ref_mem[0] = 32'hFC000000;

    // Held in reset with a fetch pending: nothing granted
    repeat (2) @(negedge clk1);
    #2;
    chk("lit_reset_if_gnt", bus.if_gnt, 0);
    chk("lit_reset_mem_en", bus.mem_en, 0);
    chk("lit_reset_cnt_if", bus.cnt_if, 0);

    // First fetch after reset
    @(negedge clk1); reset = 1'b0; bus.if_req = 1; bus.if_addr = 0;
    #2;
    chk("lit_fetch_gnt", bus.if_gnt, 1);
    chk("lit_fetch_addr", bus.mem_addr, 0);
    @(negedge clk1); bus.if_req = 0;
    #2;
    chk("lit_fetch_rvalid", bus.if_rvalid, 1);
    chk("lit_fetch_rdata", bus.rdata, 32'hFC000000);
    chk("lit_fetch_cnt", bus.cnt_if, 1);

    // Data write beats a plain fetch
    @(negedge clk1);
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 5; bus.dm_wdata = 32'h1234;
    bus.if_req = 1; bus.if_addr = 2;
    #2;
    chk("lit_wr_dm_gnt", bus.dm_gnt, 1);
    chk("lit_wr_mem_we", bus.mem_we, 1);
    chk("lit_wr_mem_addr", bus.mem_addr, 5);
    chk("lit_wr_mem_wdata", bus.mem_wdata, 32'h1234);
    chk("lit_wr_if_stall", bus.if_stall, 1);
    @(negedge clk1); bus.dm_req = 0; bus.if_req = 0;
    #2;
    chk("lit_wr_no_rvalid", bus.dm_rvalid, 0);

    // Starvation: fetch promoted after LIMIT denied cycles
    pi6 = '0; pd6 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 7; bus.if_req = 1; bus.if_addr = 3;
      #2;
      pi6[i] = bus.if_gnt; pd6[i] = bus.dm_gnt;
    end
    chk("lit_starve_if", pi6, 6'b010000);
    chk("lit_starve_dm", pd6, 6'b101111);
    @(negedge clk1); idle_inputs();

    // Halted: fetch ignored, starvation never builds
    gsum = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1); bus.halted = 1; bus.if_req = 1;
      #2;
      gsum += int'(bus.if_gnt);
    end
    chk("lit_halt_no_gnt", gsum, 0);
    chk("lit_halt_cnt_if", bus.cnt_if, 2);
    pi5 = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk1); bus.halted = 0; bus.if_req = 1; bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 9;
      #2;
      pi5[i] = bus.if_gnt;
    end
    chk("lit_post_halt_if", pi5, 5'b10000);
    @(negedge clk1); idle_inputs();

    // Loader against data
    @(negedge clk1);
    bus.ld_req = 1; bus.ld_we = 0; bus.ld_addr = 1; bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 2;
    #2;
`ifdef MIPS32_MEMARB_LOADER_EN
    chk("lit_ld_wins", bus.ld_gnt, 1);
    chk("lit_ld_dm_loses", bus.dm_gnt, 0);
`else
    chk("lit_ld_off_dm", bus.dm_gnt, 1);
    chk("lit_ld_off_ld", bus.ld_gnt, 0);
`endif
    @(negedge clk1); idle_inputs();

    // Reset right after a data read grant
    @(negedge clk1); bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 4;
    #2;
    chk("lit_rst_dm_gnt", bus.dm_gnt, 1);
    @(posedge clk1); #1; reset = 1'b1; bus.dm_req = 0;
    @(negedge clk1); #2;
    chk("lit_rst_dm_rvalid", bus.dm_rvalid, 0);
    chk("lit_rst_rdata", bus.rdata, 0);
    chk("lit_rst_cnt_dm", bus.cnt_dm, 0);
    @(negedge clk1); reset = 1'b0;
    #2;
    chk("lit_rst_after", bus.dm_rvalid, 0);
    chk("lit_rst_no_cmd", bus.mem_en, 0);

    // Random phase, requesters obey hold-until-grant with occasional drops
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk1);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if ($urandom_range(0, 15) == 0) bus.halted = ~bus.halted;
      if (bus.if_req && !g_if) begin
        if ($urandom_range(0, 15) == 0) bus.if_req = 0;
      end else begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = AW'($urandom_range(0, 15));
      end
      if (bus.dm_req && !g_dm) begin
        if ($urandom_range(0, 15) == 0) bus.dm_req = 0;
      end else begin
        bus.dm_req   = ($urandom_range(0, 1) == 1);
        bus.dm_we    = ($urandom_range(0, 1) == 1);
        bus.dm_addr  = AW'($urandom_range(0, 15));
        bus.dm_wdata = $urandom;
      end
      if (bus.ld_req && !g_ld) begin
        if ($urandom_range(0, 15) == 0) bus.ld_req = 0;
      end else begin
        bus.ld_req   = ($urandom_range(0, 3) == 0);
        bus.ld_we    = ($urandom_range(0, 1) == 1);
        bus.ld_addr  = AW'($urandom_range(0, 15));
        bus.ld_wdata = $urandom;
      end
    end
    @(negedge clk1); reset = 1'b0; idle_inputs();
    repeat (3) @(negedge clk1);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
